booth4_seq_mult: RTL and testbench

BOOTH4_SEQ_MULT -- requirements
Module: booth4_seq_mult

---
 rtl/booth4_seq_mult.sv | 106 ++++++++++
 tb/tb_booth4_seq_mult.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle, WIDTH/2+1 digits per operation.
// Operands are widened by two bits so unsigned inputs recode exactly like signed ones.
module booth4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int D  = WIDTH / 2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic signed [EW-1:0] a_ext;
  logic        [EW-1:0] b_ext;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic        [CW-1:0] cnt;
  logic        [2:0]    digit;

  function automatic logic signed [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return $signed({{2{s & v[WIDTH-1]}}, v});
  endfunction

  // Booth digit decode; the two guard bits keep 2A and -2A from overflowing EW bits.
  function automatic logic signed [AW-1:0] partial(input logic signed [EW-1:0] a,
                                                   input logic [2:0] d);
    logic signed [EW-1:0] m;
    case (d)
      3'b001, 3'b010: m = a;
      3'b011:         m = a <<< 1;
      3'b100:         m = ~(a <<< 1) + EW'(1);
      3'b101, 3'b110: m = ~a + EW'(1);
      default:        m = '0;
    endcase
    return AW'(m);
  endfunction

  always_comb begin
    digit    = 3'({b_ext, 1'b0} >> {cnt, 1'b0});
    acc_next = acc + (partial(a_ext, digit) <<< {cnt, 1'b0});
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_ext     <= '0;
      b_ext     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_ext    <= extend(A, signed_mode);
          b_ext    <= extend(B, signed_mode);
          acc      <= '0;
          cnt      <= '0;
          state    <= CALC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          // product only moves on the last digit so it stays stable outside DONE
          if (cnt == LAST) begin
            product   <= acc_next[2*WIDTH-1:0];
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult: directed WIDTH=16 vectors plus throttled random runs at 8/16/32 bits.
module tb_booth4_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic        d_rst_n, d_in_valid, d_in_ready, d_mode, d_out_valid, d_out_ready, d_busy;
  logic [15:0] d_A, d_B;
  logic [31:0] d_prod;

  booth4_seq_mult #(.WIDTH(16)) dut (
    .sys_clk(clk), .sys_rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_A), .B(d_B), .signed_mode(d_mode), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .product(d_prod), .busy(d_busy));

  // Wait (bounded) for out_valid after an accepting edge; returns edges counted.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic d_run(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    d_A = a; d_B = b; d_mode = m; d_in_valid = 1'b1; d_out_ready = 1'b0;
    lat = 0;
    while (!d_in_ready && lat < 50) begin @(negedge clk); lat++; end
    check({tag, "_ready"}, 64'(d_in_ready), 64'd1);
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_A = ~a; d_B = ~b; d_mode = ~m;
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_product"}, 64'(d_prod), 64'(exp));
    @(negedge clk); d_out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, 64'(d_in_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(d_out_valid), 64'd0);
    d_out_ready = 1'b0;
  endtask

  logic r_rst_n;
  bit   rnd_done [3] = '{default: 1'b0};

  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
    localparam int N = (g == 0) ? 5000 : ((g == 1) ? 3000 : 2000);
    logic [W-1:0]   ra, rb;
    logic           rm, riv, rir, rov, ror, rbz;
    logic [2*W-1:0] rp;

    booth4_seq_mult #(.WIDTH(W)) dut (
      .sys_clk(clk), .sys_rst_n(r_rst_n), .in_valid(riv), .in_ready(rir),
      .A(ra), .B(rb), .signed_mode(rm), .out_valid(rov),
      .out_ready(ror), .product(rp), .busy(rbz));

    initial begin
      logic [2*W-1:0] sa, sb, ex;
      bit             acc, got;
      int             t;
      riv = 1'b0; ror = 1'b0; ra = '0; rb = '0; rm = 1'b0;
      wait (r_rst_n === 1'b1);
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
        if ($urandom_range(0, 7) == 0) ra = {1'b1, {(W-1){1'b0}}};
        if ($urandom_range(0, 7) == 0) rb = {W{1'b1}};
        sa = rm ? {{W{ra[W-1]}}, ra} : {{W{1'b0}}, ra};
        sb = rm ? {{W{rb[W-1]}}, rb} : {{W{1'b0}}, rb};
        ex = sa * sb;
        acc = 1'b0; t = 0;
        while (!acc && t < 100) begin
          riv = ($urandom_range(0, 3) != 0);
          if (riv && rir) acc = 1'b1;
          else begin @(negedge clk); t++; end
        end
        check($sformatf("rnd_w%0d_accept", W), 64'(acc), 64'd1);
        got = 1'b0; t = 0;
        while (!got && t < 200) begin
          @(negedge clk);
          riv = 1'($urandom); ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
          ror = ($urandom_range(0, 3) != 0);
          if (rov && ror) begin
            check($sformatf("rnd_w%0d_product", W), 64'(rp), 64'(ex));
            got = 1'b1;
          end
          t++;
        end
        check($sformatf("rnd_w%0d_done", W), 64'(got), 64'd1);
      end
      riv = 1'b0;
      rnd_done[g] = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    r_rst_n = 1'b0;
    d_rst_n = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
    d_A = '0; d_B = '0; d_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_busy",      64'(d_busy),      64'd0);
    check("rst_in_ready",  64'(d_in_ready),  64'd1);
    check("rst_product",   64'(d_prod),      64'd0);
    @(negedge clk);
    d_rst_n = 1'b1; r_rst_n = 1'b1;

    d_run(16'h5C0B, 16'h0003, 1'b0, 32'h0001_1421, "u_5c0b_x3");
    d_run(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "s_min_sq");
    d_run(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, "u_8000_sq");
    d_run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "u_max_sq");
    d_run(16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE, "s_m1_x2");
    d_run(16'h7FFF, 16'h8000, 1'b0, 32'h3FFF_8000, "u_7fff_8000");

    // Back-pressure: hold DONE for five cycles with a new operand set already offered
    @(negedge clk);
    d_A = 16'h1234; d_B = 16'h0010; d_mode = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    wait_done(lat);
    check("hold_latency", 64'(lat), 64'd9);
    for (int k = 0; k < 5; k++) begin
      d_in_valid = 1'b1; d_A = 16'h7FFF; d_B = 16'h8000; d_mode = 1'b1;
      @(posedge clk); #1;
      check("hold_product",   64'(d_prod),      64'h0001_2340);
      check("hold_in_ready",  64'(d_in_ready),  64'd0);
      check("hold_out_valid", 64'(d_out_valid), 64'd1);
    end
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_ready", 64'(d_in_ready), 64'd1);
    d_out_ready = 1'b0;
    @(posedge clk); #1;
    check("hold_next_busy",  64'(d_busy),     64'd1);
    check("hold_next_ready", 64'(d_in_ready), 64'd0);
    d_in_valid = 1'b0;
    wait_done(lat);
    check("hold_next_latency", 64'(lat),    64'd9);
    check("hold_next_product", 64'(d_prod), 64'hC000_8000);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;

    // Reset on the fourth CALC edge, held one more edge against a pending handshake
    @(negedge clk);
    d_A = 16'h5C0B; d_B = 16'h0003; d_mode = 1'b0; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d_rst_n = 1'b0; d_in_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(d_out_valid), 64'd0);
    check("midrst_busy",      64'(d_busy),      64'd0);
    check("midrst_in_ready",  64'(d_in_ready),  64'd1);
    check("midrst_product",   64'(d_prod),      64'd0);
    @(posedge clk); #1;
    check("rst_priority_busy", 64'(d_busy), 64'd0);
    d_rst_n = 1'b1; d_in_valid = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (d_out_valid) seen++;
    end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    d_run(16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, "post_rst");

    for (int k = 0; k < 100000 && !(rnd_done[0] && rnd_done[1] && rnd_done[2]); k++)
      @(posedge clk);
    check("rnd_all_finished", 64'(rnd_done[0] && rnd_done[1] && rnd_done[2]), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
